// File: rtl/pipeline_controller_if.sv
// Control-unit bundle between the ARM pipeline controller and its datapath.
// The controller takes the slave side; the datapath (or a bench) drives the master side.
interface pipeline_controller_if;
    logic [31:0] InstrD;
    logic [3:0]  ALUFlags;
    logic        FlushE;
    logic [1:0]  RegSrcD;
    logic [1:0]  ImmSrcD;
    logic        ALUSrcE;
    logic [2:0]  ALUControlE;
    logic        MemWriteM;
    logic        MemtoRegW;
    logic        RegWriteW;
    logic        PCSrcW;
    logic        RegWriteM;
    logic        MemtoRegE;

    modport slave (
        input  InstrD, ALUFlags, FlushE,
        output RegSrcD, ImmSrcD, ALUSrcE, ALUControlE,
        output MemWriteM, MemtoRegW, RegWriteW, PCSrcW,
        output RegWriteM, MemtoRegE
    );

    modport master (
        output InstrD, ALUFlags, FlushE,
        input  RegSrcD, ImmSrcD, ALUSrcE, ALUControlE,
        input  MemWriteM, MemtoRegW, RegWriteW, PCSrcW,
        input  RegWriteM, MemtoRegE
    );
endinterface

// File: rtl/pipeline_controller.sv
// Control unit for a 5-stage ARM pipeline: decode, E/M/W control pipes,
// NZCV flags and condition-gated side effects.
module pipeline_controller (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_controller_if.slave  ctl
);

    typedef struct packed {
        logic [3:0] cond;
        logic       pcs;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic [1:0] flag_write;
    } ctl_e_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic pc_src;
    } ctl_m_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic pc_src;
    } ctl_w_t;

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    ctl_e_t     dec;
    logic [1:0] reg_src;

    ctl_e_t     e_d, e_q;
    ctl_m_t     m_d, m_q;
    ctl_w_t     w_d, w_q;
    logic [3:0] flags_d, flags_q;
    logic       cond_ex;

    assign op    = ctl.InstrD[27:26];
    assign funct = ctl.InstrD[25:20];
    assign rd    = ctl.InstrD[15:12];

    always_comb begin
        dec      = '0;
        reg_src  = 2'b00;
        dec.cond = ctl.InstrD[31:28];
        unique case (op)
            2'b00: begin
                dec.alu_src   = funct[5];
                dec.reg_write = 1'b1;
                case (funct[4:1])
                    4'b0100: begin
                        dec.alu_ctrl   = 3'b000;
                        dec.flag_write = {2{funct[0]}};
                    end
                    4'b0010: begin
                        dec.alu_ctrl   = 3'b001;
                        dec.flag_write = {2{funct[0]}};
                    end
                    4'b0000: begin
                        dec.alu_ctrl   = 3'b010;
                        dec.flag_write = {funct[0], 1'b0};
                    end
                    4'b1100: begin
                        dec.alu_ctrl   = 3'b011;
                        dec.flag_write = {funct[0], 1'b0};
                    end
                    4'b1010: begin
                        dec.alu_ctrl   = 3'b001;
                        dec.reg_write  = 1'b0;
                        dec.flag_write = 2'b11;
                    end
                    default: ;
                endcase
            end
            2'b01: begin
                dec.alu_src = 1'b1;
                if (funct[0]) begin
                    dec.reg_write  = 1'b1;
                    dec.mem_to_reg = 1'b1;
                end else begin
                    dec.mem_write = 1'b1;
                    reg_src[1]    = 1'b1;
                end
            end
            2'b10: begin
                dec.branch  = 1'b1;
                dec.alu_src = 1'b1;
                reg_src[0]  = 1'b1;
            end
            default: ;
        endcase
        // Writing R15 through the register file is a jump as well
        dec.pcs = ((rd == 4'hF) & dec.reg_write) | dec.branch;
    end

    assign ctl.RegSrcD = reg_src;
    assign ctl.ImmSrcD = op;

    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags_q;
        cond_ex = 1'b0;
        case (e_q.cond)
            4'h0: cond_ex = z;
            4'h1: cond_ex = ~z;
            4'h2: cond_ex = c;
            4'h3: cond_ex = ~c;
            4'h4: cond_ex = n;
            4'h5: cond_ex = ~n;
            4'h6: cond_ex = v;
            4'h7: cond_ex = ~v;
            4'h8: cond_ex = c & ~z;
            4'h9: cond_ex = ~c | z;
            4'hA: cond_ex = (n == v);
            4'hB: cond_ex = (n != v);
            4'hC: cond_ex = ~z & (n == v);
            4'hD: cond_ex = z | (n != v);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        e_d = ctl.FlushE ? '0 : dec;

        m_d.reg_write  = e_q.reg_write & cond_ex;
        m_d.mem_to_reg = e_q.mem_to_reg;
        m_d.mem_write  = e_q.mem_write & cond_ex;
        m_d.pc_src     = (e_q.pcs | e_q.branch) & cond_ex;

        w_d.reg_write  = m_q.reg_write;
        w_d.mem_to_reg = m_q.mem_to_reg;
        w_d.pc_src     = m_q.pc_src;

        // Flags written at end of E, so the next instr sees them
        flags_d = flags_q;
        if (e_q.flag_write[1] & cond_ex)
            flags_d[3:2] = ctl.ALUFlags[3:2];
        if (e_q.flag_write[0] & cond_ex)
            flags_d[1:0] = ctl.ALUFlags[1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q     <= '0;
            m_q     <= '0;
            w_q     <= '0;
            flags_q <= '0;
        end else begin
            e_q     <= e_d;
            m_q     <= m_d;
            w_q     <= w_d;
            flags_q <= flags_d;
        end
    end

    assign ctl.ALUSrcE     = e_q.alu_src;
    assign ctl.ALUControlE = e_q.alu_ctrl;
    assign ctl.MemtoRegE   = e_q.mem_to_reg;
    assign ctl.MemWriteM   = m_q.mem_write;
    assign ctl.RegWriteM   = m_q.reg_write;
    assign ctl.MemtoRegW   = w_q.mem_to_reg;
    assign ctl.RegWriteW   = w_q.reg_write;
    assign ctl.PCSrcW      = w_q.pc_src;

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: directed ISA cases then random traffic,
// scored against an instruction-level model through an expectation queue.
module tb_pipeline_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_controller_if bus ();

    pipeline_controller dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus.slave)
    );

    typedef struct {
        bit       writes_reg;
        bit       is_load;
        bit       is_store;
        bit       is_branch;
        bit       writes_pc;
        bit       imm_b;
        bit       sets_nz;
        bit       sets_cv;
        bit [2:0] alu;
        bit [3:0] cond;
    } sem_t;

    typedef struct packed {
        logic [1:0] reg_src;
        logic [1:0] imm_src;
        logic       alu_src_e;
        logic [2:0] alu_ctl_e;
        logic       mem_to_reg_e;
        logic       reg_write_m;
        logic       mem_write_m;
        logic       reg_write_w;
        logic       mem_to_reg_w;
        logic       pc_src_w;
    } obs_t;

    typedef struct {
        bit          rst_n;
        logic [31:0] instr;
        logic [3:0]  flags;
        bit          flush;
    } stim_t;

    obs_t  exp_q[$];
    stim_t plan[$];
    int    n_vec  = 0;
    int    n_fail = 0;

    // Architectural meaning of an instruction word
    function automatic sem_t meaning(logic [31:0] i);
        sem_t s;
        s = '{default: 0};
        s.cond = i[31:28];
        if (i[27:26] == 2'b00) begin
            s.imm_b = i[25];
            case (i[24:21])
                4'b0100: begin s.writes_reg = 1; s.alu = 3'd0;
                         s.sets_nz = i[20]; s.sets_cv = i[20]; end
                4'b0010: begin s.writes_reg = 1; s.alu = 3'd1;
                         s.sets_nz = i[20]; s.sets_cv = i[20]; end
                4'b0000: begin s.writes_reg = 1; s.alu = 3'd2;
                         s.sets_nz = i[20]; end
                4'b1100: begin s.writes_reg = 1; s.alu = 3'd3;
                         s.sets_nz = i[20]; end
                4'b1010: begin s.alu = 3'd1;
                         s.sets_nz = 1; s.sets_cv = 1; end
                default: s.writes_reg = 1;
            endcase
        end else if (i[27:26] == 2'b01) begin
            s.imm_b = 1;
            if (i[20]) begin
                s.writes_reg = 1;
                s.is_load    = 1;
            end else begin
                s.is_store = 1;
            end
        end else if (i[27:26] == 2'b10) begin
            s.is_branch = 1;
            s.imm_b     = 1;
        end
        s.writes_pc = s.is_branch || (s.writes_reg && i[15:12] == 4'hF);
        return s;
    endfunction

    function automatic bit passes(bit [3:0] c, bit [3:0] f);
        bit n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1;
            default: return 0;
        endcase
    endfunction

    // Model: what sits in each stage, plus architectural flags
    bit       e_full;
    sem_t     e_sem;
    bit       m_rw, m_mw, m_ld, m_pc;
    bit       w_rw, w_ld, w_pc;
    bit [3:0] nzcv;

    task automatic model_edge(input stim_t s);
        bit go;
        if (!s.rst_n) begin
            e_full = 0;
            e_sem  = '{default: 0};
            {m_rw, m_mw, m_ld, m_pc} = '0;
            {w_rw, w_ld, w_pc} = '0;
            nzcv = '0;
        end else begin
            go = e_full && passes(e_sem.cond, nzcv);
            w_rw = m_rw;
            w_ld = m_ld;
            w_pc = m_pc;
            m_rw = go && e_sem.writes_reg;
            m_mw = go && e_sem.is_store;
            m_ld = e_full && e_sem.is_load;
            m_pc = go && e_sem.writes_pc;
            if (go && e_sem.sets_nz) nzcv[3:2] = s.flags[3:2];
            if (go && e_sem.sets_cv) nzcv[1:0] = s.flags[1:0];
            e_full = !s.flush;
            e_sem  = meaning(s.instr);
        end
    endtask

    function automatic obs_t expect_now(stim_t s);
        obs_t o;
        sem_t d;
        d = meaning(s.instr);
        o.reg_src      = {d.is_store, d.is_branch};
        o.imm_src      = s.instr[27:26];
        o.alu_src_e    = e_full && e_sem.imm_b;
        o.alu_ctl_e    = e_full ? e_sem.alu : 3'd0;
        o.mem_to_reg_e = e_full && e_sem.is_load;
        o.reg_write_m  = m_rw;
        o.mem_write_m  = m_mw;
        o.reg_write_w  = w_rw;
        o.mem_to_reg_w = w_ld;
        o.pc_src_w     = w_pc;
        return o;
    endfunction

    function automatic stim_t mk(bit r, logic [31:0] i, logic [3:0] f, bit fl);
        stim_t s;
        s.rst_n = r;
        s.instr = i;
        s.flags = f;
        s.flush = fl;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        bit [3:0]    cmds [7] = '{4'h4, 4'h2, 4'h0, 4'hC, 4'hA, 4'h1, 4'hD};
        bit [3:0]    cond, rd;
        logic [31:0] i;
        int          kind;
        cond = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hE;
        rd   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
        kind = $urandom_range(0, 9);
        if (kind < 5)
            i = {cond, 2'b00, 1'($urandom), cmds[$urandom_range(0, 6)],
                 1'($urandom), 4'($urandom), rd, 12'($urandom)};
        else if (kind < 7)
            i = {cond, 2'b01, 5'b01100, 1'($urandom),
                 4'($urandom), rd, 12'($urandom)};
        else if (kind < 9)
            i = {cond, 3'b101, 1'($urandom), 24'($urandom)};
        else
            i = {cond, 2'b11, 26'($urandom)};
        return mk($urandom_range(0, 49) != 0, i, 4'($urandom),
                  $urandom_range(0, 7) == 0);
    endfunction

    task automatic drive(input stim_t s);
        reset        = s.rst_n;
        bus.InstrD   = s.instr;
        bus.ALUFlags = s.flags;
        bus.FlushE   = s.flush;
    endtask

    // Monitor: every cycle the DUT presents a full control vector
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.RegSrcD, bus.ImmSrcD, bus.ALUSrcE, bus.ALUControlE,
                     bus.MemtoRegE, bus.RegWriteM, bus.MemWriteM,
                     bus.RegWriteW, bus.MemtoRegW, bus.PCSrcW};
                n_vec++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL ctl_vec #%0d instr=%h got %b want %b",
                             n_vec, bus.InstrD, a, e);
                end
            end
        end
    end

    localparam logic [31:0] NOP  = 32'hEC000000;
    localparam logic [31:0] SUBS = 32'hE0500000;

    initial begin
        stim_t cur;
        bit    known;
        known = 0;
        cur   = mk(0, 32'hE2821005, 4'h0, 0);
        drive(cur);

        plan.push_back(mk(0, 32'hE2821005, 4'h0, 0));
        plan.push_back(mk(0, 32'hE2821005, 4'h0, 0));
        plan.push_back(mk(1, 32'hE2821005, 4'h0, 0));
        plan.push_back(mk(1, 32'hE5821004, 4'h0, 0));
        plan.push_back(mk(1, 32'hE5921004, 4'h0, 0));
        plan.push_back(mk(1, NOP, 4'h0, 0));
        plan.push_back(mk(1, SUBS, 4'h0, 0));
        plan.push_back(mk(1, 32'h0A000002, 4'b0100, 0));
        plan.push_back(mk(1, NOP, 4'h0, 0));
        plan.push_back(mk(1, SUBS, 4'h0, 0));
        plan.push_back(mk(1, 32'h1A000002, 4'b0100, 0));
        plan.push_back(mk(1, NOP, 4'h0, 0));
        plan.push_back(mk(1, SUBS, 4'h0, 0));
        plan.push_back(mk(1, 32'h02821005, 4'b0000, 0));
        plan.push_back(mk(1, 32'hE282F005, 4'h0, 0));
        plan.push_back(mk(1, NOP, 4'h0, 0));
        plan.push_back(mk(1, SUBS, 4'h0, 1));
        plan.push_back(mk(1, 32'h0A000002, 4'b0100, 0));
        plan.push_back(mk(1, NOP, 4'h0, 0));
        plan.push_back(mk(1, NOP, 4'h0, 0));
        plan.push_back(mk(1, NOP, 4'h0, 0));
        repeat (600) plan.push_back(rand_stim());

        foreach (plan[k]) begin
            @(posedge clk);
            #1;
            model_edge(cur);
            if (!cur.rst_n) known = 1;
            cur = plan[k];
            drive(cur);
            if (known) exp_q.push_back(expect_now(cur));
        end
        @(posedge clk);
        #1;
        model_edge(cur);
        cur = mk(1, NOP, 4'h0, 0);
        drive(cur);
        exp_q.push_back(expect_now(cur));
        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
